// File: rtl/mult_unit.sv
// mult_unit: multi-cycle shift-and-add multiplier for MULT/MULTU with
// architectural HI/LO registers and MTHI/MTLO write ports.
// One add-and-shift per cycle for WIDTH cycles, then one sign-fix cycle.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH:0]    acc_hi_q;   // upper half plus carry bit
  logic [WIDTH-1:0]  acc_lo_q;   // lower half, initially the multiplier
  logic [WIDTH-1:0]  mcand_q;    // multiplicand magnitude
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;

  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] result_d;

  // Operand magnitudes, one add step of the accumulator, and the sign-fixed product.
  // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
  always_comb begin
    mag_a_d  = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    mag_b_d  = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    sum_d    = acc_hi_q + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_d   = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    result_d = neg_q ? (~prod_d + 1'b1) : prod_d;
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // start takes priority; any coincident MTHI/MTLO is dropped
            state_q  <= S_MUL;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= mag_b_d;
            mcand_q  <= mag_a_d;
            neg_q    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        S_MUL: begin
          acc_hi_q <= {1'b0, sum_d[WIDTH:1]};
          acc_lo_q <= {sum_d[0], acc_lo_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= result_d[2*WIDTH-1:WIDTH];
          lo_q    <= result_d[WIDTH-1:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
